// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode and burst-state encodings shared by the LED pattern controller
package led_pattern_pkg;
  localparam int PAUSE_HALVES_DEF = 4;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, PAUSE} burst_st_e;
endpackage

// File: rtl/led_chan.sv
// led_chan: one LED channel; half-period phase and BLINK/BURST sequencing on the shared tick
module led_chan
  import led_pattern_pkg::*;
#(
  parameter int HALF_W       = 12,
  parameter int BURST_W      = 3,
  parameter int PAUSE_HALVES = PAUSE_HALVES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync,
  input  logic               tick,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [HALF_W-1:0]  half_per,
  input  logic [BURST_W-1:0] burst_n,
  output logic               led
);
  localparam int PW = PAUSE_HALVES > 1 ? $clog2(PAUSE_HALVES) : 1;
  logic [2:0]         cfg_q;
  burst_st_e          state_q, state_d;
  logic [HALF_W-1:0]  phase_q, phase_d, h_eff;
  logic [BURST_W-1:0] pulse_q, pulse_d;
  logic [PW-1:0]      pause_q, pause_d;
  logic               led_q, led_d, chg, act, evt, last_pulse, pause_end;
  always_comb begin
    chg        = {en, mode} != cfg_q;
    act        = cfg_q[2] && (cfg_q[1:0] == MODE_BLINK || cfg_q[1:0] == MODE_BURST);
    h_eff      = half_per == '0 ? HALF_W'(1) : half_per;
    evt        = tick && phase_q >= h_eff - 1'b1;
    last_pulse = {1'b0, pulse_q} + 1'b1 >= {1'b0, burst_n};
    pause_end  = pause_q == PW'(PAUSE_HALVES - 1);
    state_d    = state_q;
    phase_d    = phase_q;
    pulse_d    = pulse_q;
    pause_d    = pause_q;
    led_d      = led_q;
    // any config change or sync restarts the pattern from IDLE with led low for one cycle
    if (sync || chg || !act) begin
      state_d = IDLE;
      phase_d = '0;
      pulse_d = '0;
      pause_d = '0;
      led_d   = !sync && !chg && cfg_q == {1'b1, MODE_ON};
    end else begin
      phase_d = !tick ? phase_q : evt ? '0 : phase_q + 1'b1;
      if (evt && cfg_q[1:0] == MODE_BURST)
        case (state_q)
          IDLE: state_d = burst_n == '0 ? IDLE : HIGH;
          HIGH: state_d = LOW;
          LOW: begin
            pulse_d = last_pulse ? '0 : pulse_q + 1'b1;
            state_d = last_pulse ? PAUSE : HIGH;
          end
          default: begin
            pause_d = pause_end ? '0 : pause_q + 1'b1;
            state_d = !pause_end ? PAUSE : burst_n == '0 ? IDLE : HIGH;
          end
        endcase
      led_d = cfg_q[1:0] == MODE_BLINK ? led_q ^ evt : state_d == HIGH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q   <= '0;
      state_q <= IDLE;
      phase_q <= '0;
      pulse_q <= '0;
      pause_q <= '0;
      led_q   <= 1'b0;
    end else begin
      cfg_q   <= {en, mode};
      state_q <= state_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      pause_q <= pause_d;
      led_q   <= led_d;
    end
  end
  assign led = led_q;
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: N_CH LED pattern channels sharing one tick prescaler for coherent phases
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int N_CH         = 4,
  parameter int HALF_W       = 12,
  parameter int BURST_W      = 3,
  parameter int PAUSE_HALVES = PAUSE_HALVES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sync,
  input  logic [N_CH-1:0]           en,
  input  logic [2*N_CH-1:0]         mode,
  input  logic [HALF_W*N_CH-1:0]    half_per,
  input  logic [BURST_W*N_CH-1:0]   burst_n,
  output logic [N_CH-1:0]           led,
  output logic                      tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q;
  logic          tick_q;
  always_ff @(posedge clk) begin
    if (rst || sync) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q == CW'(DIV - 1) ? '0 : cnt_q + 1'b1;
      tick_q <= cnt_q == CW'(DIV - 1);
    end
  end
  assign tick = tick_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_chan #(
      .HALF_W      (HALF_W),
      .BURST_W     (BURST_W),
      .PAUSE_HALVES(PAUSE_HALVES)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .sync    (sync),
      .tick    (tick_q),
      .en      (en[i]),
      .mode    (mode[2*i +: 2]),
      .half_per(half_per[HALF_W*i +: HALF_W]),
      .burst_n (burst_n[BURST_W*i +: BURST_W]),
      .led     (led[i])
    );
  end
endmodule
